// File: rtl/l_class_fifo_n.sv
// N-deep, W-wide FIFO with enq/deq/first method handshake, occupancy count,
// synchronous clear and a sticky protocol-error flag.
module l_class_fifo_n #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  output logic             enq__RDY,
  input  logic             enq__ENA,
  input  logic [WIDTH-1:0] enq_v,
  output logic             deq__RDY,
  input  logic             deq__ENA,
  output logic             first__RDY,
  output logic [WIDTH-1:0] first,
  input  logic             clear__ENA,
  output logic             notFull,
  output logic             notEmpty,
  output logic [CW-1:0]    count,
  output logic             err
);

  localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rp, wp, rp_nxt, wp_nxt;
  logic [CW-1:0]    count_nxt;
  logic             enq_acc, deq_acc, err_set;

  // Status derives from count alone so no RDY depends on any ENA.
  always_comb begin
    enq__RDY   = (count != FULL);
    deq__RDY   = (count != '0);
    first__RDY = deq__RDY;
    notFull    = enq__RDY;
    notEmpty   = deq__RDY;
    first      = deq__RDY ? mem[rp] : '0;
  end

  always_comb begin
    enq_acc = enq__ENA & enq__RDY & ~clear__ENA;
    deq_acc = deq__ENA & deq__RDY & ~clear__ENA;
    err_set = ~clear__ENA & ((enq__ENA & ~enq__RDY) | (deq__ENA & ~deq__RDY));
    rp_nxt  = (rp == LAST) ? '0 : rp + 1'b1;
    wp_nxt  = (wp == LAST) ? '0 : wp + 1'b1;
    case ({enq_acc, deq_acc})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
      err   <= 1'b0;
    end else if (clear__ENA) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      if (enq_acc) wp <= wp_nxt;
      if (deq_acc) rp <= rp_nxt;
      count <= count_nxt;
      if (err_set) err <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset and clear.
  always_ff @(posedge CLK) begin
    if (enq_acc) mem[wp] <= enq_v;
  end

endmodule

// File: tb/tb_l_class_fifo_n.sv
// Scoreboard bench: DEPTH=4 and DEPTH=3 FIFOs share one stimulus stream and
// are each checked against a queue-based model every cycle.
module tb_l_class_fifo_n;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        enq__ENA = 1'b0, deq__ENA = 1'b0, clear__ENA = 1'b0;
  logic [31:0] enq_v = '0;

  logic        er4, dr4, fr4, nf4, ne4, e4;
  logic [31:0] f4;
  logic [2:0]  c4;
  logic        er3, dr3, fr3, nf3, ne3, e3;
  logic [31:0] f3;
  logic [1:0]  c3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mq4[$], mq3[$], exp4[$], exp3[$];
  logic        me4 = 1'b0, me3 = 1'b0;

  always #5 CLK = ~CLK;

  l_class_fifo_n #(.WIDTH(32), .DEPTH(4)) u_d4 (
    .CLK(CLK), .nRST(nRST),
    .enq__RDY(er4), .enq__ENA(enq__ENA), .enq_v(enq_v),
    .deq__RDY(dr4), .deq__ENA(deq__ENA),
    .first__RDY(fr4), .first(f4), .clear__ENA(clear__ENA),
    .notFull(nf4), .notEmpty(ne4), .count(c4), .err(e4)
  );

  l_class_fifo_n #(.WIDTH(32), .DEPTH(3)) u_d3 (
    .CLK(CLK), .nRST(nRST),
    .enq__RDY(er3), .enq__ENA(enq__ENA), .enq_v(enq_v),
    .deq__RDY(dr3), .deq__ENA(deq__ENA),
    .first__RDY(fr3), .first(f3), .clear__ENA(clear__ENA),
    .notFull(nf3), .notEmpty(ne3), .count(c3), .err(e3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_dut(input string t, input int sz, input int dep,
                           input logic [31:0] head, input logic me,
                           input logic erdy, input logic nf, input logic drdy,
                           input logic frdy, input logic ne, input logic [31:0] f,
                           input logic [31:0] cnt, input logic er);
    chk({t, "_count"},    cnt,  sz);
    chk({t, "_enq_rdy"},  {31'b0, erdy}, {31'b0, sz < dep});
    chk({t, "_notFull"},  {31'b0, nf},   {31'b0, sz < dep});
    chk({t, "_deq_rdy"},  {31'b0, drdy}, {31'b0, sz > 0});
    chk({t, "_first_rdy"},{31'b0, frdy}, {31'b0, sz > 0});
    chk({t, "_notEmpty"}, {31'b0, ne},   {31'b0, sz > 0});
    chk({t, "_first"},    f,    (sz > 0) ? head : 32'h0);
    chk({t, "_err"},      {31'b0, er},   {31'b0, me});
  endtask

  // Reference model: the FIFO as a bounded queue, updated at each active edge.
  always @(posedge CLK) begin
    bit ae, ad;
    if (nRST) begin
      if (clear__ENA) begin
        mq4.delete();
        mq3.delete();
      end else begin
        ae = enq__ENA && (mq4.size() < 4);
        ad = deq__ENA && (mq4.size() > 0);
        if ((enq__ENA && !ae) || (deq__ENA && !ad)) me4 = 1'b1;
        if (ad) void'(mq4.pop_front());
        if (ae) mq4.push_back(enq_v);
        ae = enq__ENA && (mq3.size() < 3);
        ad = deq__ENA && (mq3.size() > 0);
        if ((enq__ENA && !ae) || (deq__ENA && !ad)) me3 = 1'b1;
        if (ad) void'(mq3.pop_front());
        if (ae) mq3.push_back(enq_v);
      end
    end
  end

  // Monitor: per-cycle status against the model, plus popped values from the scoreboard.
  always @(negedge CLK) begin
    check_dut("d4", mq4.size(), 4, (mq4.size() > 0) ? mq4[0] : 32'h0, me4,
              er4, nf4, dr4, fr4, ne4, f4, {29'b0, c4}, e4);
    check_dut("d3", mq3.size(), 3, (mq3.size() > 0) ? mq3[0] : 32'h0, me3,
              er3, nf3, dr3, fr3, ne3, f3, {30'b0, c3}, e3);
    if (nRST && deq__ENA && !clear__ENA && dr4) begin
      if (exp4.size() == 0) chk("d4_pop_unexpected", {31'b0, dr4}, 32'h0);
      else chk("d4_pop", f4, exp4.pop_front());
    end
    if (nRST && deq__ENA && !clear__ENA && dr3) begin
      if (exp3.size() == 0) chk("d3_pop_unexpected", {31'b0, dr3}, 32'h0);
      else chk("d3_pop", f3, exp3.pop_front());
    end
  end

  task automatic step(input logic e, input logic [31:0] v, input logic d, input logic c);
    @(posedge CLK);
    #1;
    enq__ENA   = e;
    enq_v      = v;
    deq__ENA   = d;
    clear__ENA = c;
    if (d && !c) begin
      if (mq4.size() > 0) exp4.push_back(mq4[0]);
      if (mq3.size() > 0) exp3.push_back(mq3[0]);
    end
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    enq__ENA = 1'b0; deq__ENA = 1'b0; clear__ENA = 1'b0;
    #2;
    nRST = 1'b0;
    mq4.delete(); mq3.delete(); exp4.delete(); exp3.delete();
    me4 = 1'b0; me3 = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    #1 nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;

    // Mid-cycle asynchronous reset with count = 3 and err set.
    step(0, 0, 1, 0);
    step(1, 32'hA1, 0, 0);
    step(1, 32'hA2, 0, 0);
    step(1, 32'hA3, 0, 0);
    @(posedge CLK);
    #1;
    enq__ENA = 1'b0; deq__ENA = 1'b0;
    #2;
    nRST = 1'b0;
    mq4.delete(); mq3.delete(); exp4.delete(); exp3.delete();
    me4 = 1'b0; me3 = 1'b0;
    #1;
    chk("rst_count4", {29'b0, c4}, 32'h0);
    chk("rst_enq_rdy4", {31'b0, er4}, 32'h1);
    chk("rst_deq_rdy4", {31'b0, dr4}, 32'h0);
    chk("rst_first4", f4, 32'h0);
    chk("rst_err4", {31'b0, e4}, 32'h0);
    chk("rst_count3", {30'b0, c3}, 32'h0);
    chk("rst_err3", {31'b0, e3}, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;

    // Fill and drain.
    step(1, 32'h11, 0, 0);
    step(1, 32'h22, 0, 0);
    step(1, 32'h33, 0, 0);
    step(1, 32'h44, 0, 0);
    for (int unsigned i = 0; i < 4; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Wrap-around with simultaneous enq/deq at count = 2.
    do_reset();
    step(1, 32'h100, 0, 0);
    step(1, 32'h101, 0, 0);
    for (int unsigned k = 0; k < 10; k++) step(1, 32'h200 + k, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // Full with deq+enq together.
    do_reset();
    for (int unsigned i = 0; i < 4; i++) step(1, 32'h60 + i, 0, 0);
    step(1, 32'h55, 1, 0);
    for (int unsigned i = 0; i < 4; i++) step(0, 0, 1, 0);

    // Empty with deq, then enq.
    do_reset();
    step(0, 0, 1, 0);
    step(1, 32'hAA, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);

    // Clear together with enq.
    do_reset();
    step(0, 0, 1, 0);
    step(1, 32'h71, 0, 0);
    step(1, 32'h72, 0, 0);
    step(1, 32'h73, 0, 0);
    step(1, 32'h77, 0, 1);
    step(1, 32'h81, 0, 0);
    step(1, 32'h82, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // Randomized traffic with occasional clears and resets.
    do_reset();
    for (int unsigned n = 0; n < 600; n++) begin
      if (n % 150 == 149) do_reset();
      step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 55,
           $urandom_range(0, 39) == 0);
    end
    step(0, 0, 0, 0);
    @(negedge CLK);
    #1;
    chk("exp4_drained", exp4.size(), 32'h0);
    chk("exp3_drained", exp3.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
